count_wrap_monitor: RTL and testbench



---
 rtl/count_wrap_monitor_pkg.sv | 19 +
 rtl/count_edge_detect.sv | 57 +++++
 rtl/count_wrap_monitor.sv | 86 ++++++++
 tb/tb_count_wrap_monitor.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/count_wrap_monitor_pkg.sv
// Shared types and constants for the count wrap monitor: FSM encoding,
// default widths and event bit positions used by the edge detector.
package count_wrap_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRED = 2'd2
    } state_t;

    localparam int CNT_W_DEF  = 4;
    localparam int WRAP_W_DEF = 8;

    localparam int EV_WRAP  = 0;
    localparam int EV_CLEAR = 1;
    localparam int EV_MATCH = 2;
    localparam int NUM_EV   = 3;

endpackage

// File: rtl/count_edge_detect.sv
// Tracks the previous count sample and turns count transitions into
// registered wrap / external-clear / compare-match pulses.
module count_edge_detect
    import count_wrap_monitor_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [CNT_W-1:0] count_in,
    input  logic [CNT_W-1:0] cmp_val,
    output logic             wrap_ev,
    output logic             wrap_pulse,
    output logic             clr_seen,
    output logic             match_pulse
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]  prev_cnt;
    logic [CNT_W-1:0]  prev_cmp;
    logic              prev_valid;
    logic [NUM_EV-1:0] ev;
    logic [NUM_EV-1:0] ev_q;

    always_comb begin
        ev = '0;
        ev[EV_WRAP]  = prev_valid && (prev_cnt == CNT_MAX) && (count_in == '0);
        ev[EV_CLEAR] = prev_valid && (count_in == '0) &&
                       (prev_cnt != '0) && (prev_cnt != CNT_MAX);
        // A changed compare value re-qualifies a count that is already sitting on it.
        ev[EV_MATCH] = prev_valid && (count_in == cmp_val) &&
                       ((prev_cnt != cmp_val) || (cmp_val != prev_cmp));
    end

    // Unregistered wrap lets the parent's FSM act on the same edge as wrap_pulse.
    assign wrap_ev = ev[EV_WRAP];

    always_ff @(posedge clk) begin
        if (!clear) begin
            prev_cnt   <= '0;
            prev_cmp   <= '0;
            prev_valid <= 1'b0;
            ev_q       <= '0;
        end else begin
            prev_cnt   <= count_in;
            prev_cmp   <= cmp_val;
            prev_valid <= 1'b1;
            ev_q       <= ev;
        end
    end

    assign wrap_pulse  = ev_q[EV_WRAP];
    assign clr_seen    = ev_q[EV_CLEAR];
    assign match_pulse = ev_q[EV_MATCH];

endmodule

// File: rtl/count_wrap_monitor.sv
// Watches an upstream counter, counts natural wraps and fires once a
// programmable number of wraps has been seen after an arm request.
module count_wrap_monitor
    import count_wrap_monitor_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int WRAP_W = WRAP_W_DEF
) (
    input  logic              clk,
    input  logic              clear,
    input  logic [CNT_W-1:0]  count_in,
    input  logic [CNT_W-1:0]  cmp_val,
    input  logic              arm,
    input  logic              ack,
    input  logic [WRAP_W-1:0] wrap_limit,
    output logic              match_pulse,
    output logic              wrap_pulse,
    output logic              clr_seen,
    output logic              fire,
    output logic              done,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              busy
);

    localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

    state_t            state, state_nxt;
    logic [WRAP_W-1:0] limit_q;
    logic [WRAP_W-1:0] wrap_inc;
    logic              wrap_ev;
    logic              hit;

    count_edge_detect #(.CNT_W(CNT_W)) u_edge (
        .clk         (clk),
        .clear       (clear),
        .count_in    (count_in),
        .cmp_val     (cmp_val),
        .wrap_ev     (wrap_ev),
        .wrap_pulse  (wrap_pulse),
        .clr_seen    (clr_seen),
        .match_pulse (match_pulse)
    );

    assign wrap_inc = (wrap_cnt == WRAP_MAX) ? wrap_cnt : wrap_cnt + 1'b1;
    // A zero limit is satisfied immediately, without waiting for a wrap.
    assign hit = (limit_q == '0) || (wrap_ev && (wrap_inc == limit_q));

    always_ff @(posedge clk) begin
        if (!clear) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arm) state_nxt = ARMED;
            ARMED:   if (!arm && hit) state_nxt = FIRED;
            FIRED:   if (arm) state_nxt = ARMED;
                     else if (ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ARMED);
        done = (state == FIRED);
    end

    // Arm in any state restarts the run and wins over a coincident wrap.
    always_ff @(posedge clk) begin
        if (!clear) begin
            wrap_cnt <= '0;
            limit_q  <= '0;
            fire     <= 1'b0;
        end else begin
            fire <= (state == ARMED) && (state_nxt == FIRED);
            if (arm) begin
                wrap_cnt <= '0;
                limit_q  <= wrap_limit;
            end else if (state == ARMED && wrap_ev) begin
                wrap_cnt <= wrap_inc;
            end
        end
    end

endmodule

// File: tb/tb_count_wrap_monitor.sv
// Directed and randomized checks of count_wrap_monitor against a
// behavioural model of the wrap/clear/match rules and the arm/fire run.
module tb_count_wrap_monitor;

    logic       clk = 1'b0;
    logic       clear;
    logic [3:0] count_in;
    logic [3:0] cmp_val;
    logic       arm;
    logic       ack;
    logic [7:0] wrap_limit;
    logic       match_pulse, wrap_pulse, clr_seen, fire, done, busy;
    logic [7:0] wrap_cnt;

    int total = 0;
    int bad   = 0;

    count_wrap_monitor #(.CNT_W(4), .WRAP_W(8)) dut (
        .clk         (clk),
        .clear       (clear),
        .count_in    (count_in),
        .cmp_val     (cmp_val),
        .arm         (arm),
        .ack         (ack),
        .wrap_limit  (wrap_limit),
        .match_pulse (match_pulse),
        .wrap_pulse  (wrap_pulse),
        .clr_seen    (clr_seen),
        .fire        (fire),
        .done        (done),
        .wrap_cnt    (wrap_cnt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 = idle, 1 = counting wraps, 2 = target reached.
    int m_prev, m_pcmp, m_phase, m_lim, e_cnt;
    bit m_pv, chk_en;
    bit e_wrap, e_clr, e_match, e_fire;

    always @(posedge clk) begin
        bit w, c, m;
        if (!clear) begin
            m_prev = 0; m_pv = 0; m_pcmp = 0; m_phase = 0; m_lim = 0; e_cnt = 0;
            e_wrap = 0; e_clr = 0; e_match = 0; e_fire = 0;
            chk_en = 1;
        end else begin
            w = m_pv && m_prev == 15 && int'(count_in) == 0;
            c = m_pv && int'(count_in) == 0 && m_prev != 0 && m_prev != 15;
            m = m_pv && int'(count_in) == int'(cmp_val) &&
                (m_prev != int'(cmp_val) || int'(cmp_val) != m_pcmp);
            e_fire = 0;
            if (arm) begin
                m_phase = 1; e_cnt = 0; m_lim = int'(wrap_limit);
            end else if (m_phase == 1) begin
                if (w && e_cnt < 255) e_cnt = e_cnt + 1;
                if (m_lim == 0 || (w && e_cnt == m_lim)) begin
                    m_phase = 2; e_fire = 1;
                end
            end else if (m_phase == 2 && ack) begin
                m_phase = 0;
            end
            e_wrap = w; e_clr = c; e_match = m;
            m_prev = int'(count_in); m_pcmp = int'(cmp_val); m_pv = 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("wrap_pulse",  wrap_pulse,  e_wrap);
            chk("clr_seen",    clr_seen,    e_clr);
            chk("match_pulse", match_pulse, e_match);
            chk("fire",        fire,        e_fire);
            chk("done",        done,        m_phase == 2);
            chk("busy",        busy,        m_phase == 1);
            chk("wrap_cnt",    wrap_cnt,    e_cnt);
        end
    end

    int cur;

    task automatic step(input logic [3:0] c);
        count_in = c;
        @(posedge clk);
        #2;
    endtask

    task automatic tick();
        cur = (cur + 1) % 16;
        step(cur[3:0]);
    endtask

    initial begin
        int nw, nm, nf, r;
        clear = 0; arm = 0; ack = 0; cmp_val = 4'd5; wrap_limit = 8'd0; count_in = 4'd0;
        cur = 0;
        step(4'd0);
        step(4'd0);
        chk("rst_wrap_cnt", wrap_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        // Natural wrap after a full ramp
        clear = 1;
        step(4'd0);
        chk("first_no_pulse", {wrap_pulse, clr_seen, match_pulse}, 0);
        nw = 0;
        for (int i = 0; i < 15; i++) begin tick(); nw += int'(wrap_pulse); end
        tick();
        chk("no_early_wrap", nw, 0);
        chk("wrap_once", wrap_pulse, 1);
        chk("wrap_not_clr", clr_seen, 0);
        step(4'd0);
        chk("hold0_quiet", {wrap_pulse, clr_seen}, 0);

        // External clear from mid-count
        for (int i = 1; i <= 6; i++) step(4'(i));
        cur = 0;
        step(4'd0);
        chk("clr_seen", clr_seen, 1);
        chk("clr_not_wrap", wrap_pulse, 0);
        step(4'd0);
        chk("clr_hold_quiet", clr_seen, 0);

        // Compare matches across three periods, then a held match
        cmp_val = 4'd9;
        nm = 0;
        for (int i = 0; i < 48; i++) begin tick(); nm += int'(match_pulse); end
        chk("match_3x", nm, 3);
        nm = 0;
        for (int i = 0; i < 9; i++) begin tick(); nm += int'(match_pulse); end
        for (int i = 0; i < 5; i++) begin step(4'd9); nm += int'(match_pulse); end
        chk("match_held_once", nm, 1);

        // Fire after three wraps, then acknowledge
        wrap_limit = 8'd3; arm = 1; tick(); arm = 0;
        chk("armed_busy", busy, 1);
        nf = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (fire) begin
                nf++;
                chk("fire_with_wrap", wrap_pulse, 1);
                chk("fire_wrap_cnt", wrap_cnt, 3);
            end
        end
        chk("fire_once", nf, 1);
        chk("done_sticky", done, 1);
        ack = 1; tick(); ack = 0;
        chk("ack_done", done, 0);
        chk("ack_busy", busy, 0);

        // Zero limit fires one cycle after arm; arm beats ack in FIRED
        wrap_limit = 8'd0; arm = 1; tick(); arm = 0;
        chk("lim0_no_fire_yet", fire, 0);
        tick();
        chk("lim0_fire", fire, 1);
        arm = 1; ack = 1; tick(); arm = 0; ack = 0;
        chk("rearm_busy", busy, 1);
        chk("rearm_done", done, 0);
        chk("rearm_cnt", wrap_cnt, 0);
        tick(); tick();
        ack = 1; tick(); ack = 0;

        // Reset mid-run abandons it; the first post-reset sample cannot pulse
        wrap_limit = 8'd5; arm = 1; tick(); arm = 0;
        for (int i = 0; i < 40 && wrap_cnt != 8'd2; i++) tick();
        chk("midrun_cnt", wrap_cnt, 2);
        for (int i = 0; i < 16 && cur != 14; i++) tick();
        clear = 0; tick();
        chk("midrst_outputs", {match_pulse, wrap_pulse, clr_seen, fire, done, busy}, 0);
        chk("midrst_cnt", wrap_cnt, 0);
        clear = 1; tick();
        chk("post_rst_no_wrap", wrap_pulse, 0);
        chk("post_rst_no_fire", fire, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70)      cur = (cur + 1) % 16;
            else if (r < 90 && r >= 80) cur = 0;
            else if (r >= 90) cur = int'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) cmp_val = 4'($urandom_range(0, 15));
            arm = ($urandom_range(0, 39) == 0);
            ack = ($urandom_range(0, 5) == 0);
            wrap_limit = 8'($urandom_range(0, 3));
            clear = ($urandom_range(0, 299) != 0);
            step(cur[3:0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
